// File: rtl/mem_access_pkg.sv
// Shared widths, aluop codes, write-enable levels and the memory-stage state encoding.
package mem_access_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int DataBeBus  = 4;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemBusy = 2'd1,
    MemDone = 2'd2
  } mem_state_e;

  function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Lane steering for the data bus: byte enables, replicated store data,
// load extraction with sign/zero extension, and misalignment detection.
module mem_data_align
  import mem_access_pkg::*;
(
  input  logic [AluOpBus-1:0]  aluop_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [RegBus-1:0]    reg2_i,
  input  logic [RegBus-1:0]    rdata_i,
  output logic                 is_mem_o,
  output logic                 is_store_o,
  output logic                 misalign_o,
  output logic [DataBeBus-1:0] be_o,
  output logic [RegBus-1:0]    wdata_o,
  output logic [RegBus-1:0]    load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word (little-endian).
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Decode the access size and build bus-side and load-side values.
  always_comb begin
    is_mem_o    = 1'b1;
    is_store_o  = is_store_op(aluop_i);
    misalign_o  = 1'b0;
    be_o        = 4'b0000;
    wdata_o     = '0;
    load_data_o = '0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{reg2_i[7:0]}};
        load_data_o = (aluop_i == EXE_LB_OP) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        misalign_o  = addr_lo_i[0];
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{reg2_i[15:0]}};
        load_data_o = (aluop_i == EXE_LH_OP) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0, half_sel};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        misalign_o  = |addr_lo_i;
        be_o        = 4'b1111;
        wdata_o     = reg2_i;
        load_data_o = rdata_i;
      end
      default: is_mem_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives a single-outstanding req/ack SRAM bus
// for loads/stores, stalls the pipeline while a request is in flight, and
// passes non-memory results straight through to write-back.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [RegBus-1:0]     mem_wdata_i,
  input  logic [AluOpBus-1:0]   mem_aluop_i,
  input  logic [RegBus-1:0]     mem_mem_addr_i,
  input  logic [RegBus-1:0]     mem_reg2_i,
  input  logic [RegBus-1:0]     data_rdata,
  input  logic                  data_ack,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  data_req,
  output logic                  data_we,
  output logic [RegBus-1:0]     data_addr,
  output logic [DataBeBus-1:0]  data_be,
  output logic [RegBus-1:0]     data_wdata,
  output logic                  stallreq,
  output logic                  misalign
);

  mem_state_e           state_q;
  logic                 req_q, we_q;
  logic [RegBus-1:0]    addr_q, wdata_q, rdata_q;
  logic [DataBeBus-1:0] be_q;

  logic                 is_mem, is_store, mis;
  logic [DataBeBus-1:0] be;
  logic [RegBus-1:0]    st_data, ld_data;

  // Load extension always reads the captured word; it is only consumed in DONE.
  mem_data_align u_align (
    .aluop_i     (mem_aluop_i),
    .addr_lo_i   (mem_mem_addr_i[1:0]),
    .reg2_i      (mem_reg2_i),
    .rdata_i     (rdata_q),
    .is_mem_o    (is_mem),
    .is_store_o  (is_store),
    .misalign_o  (mis),
    .be_o        (be),
    .wdata_o     (st_data),
    .load_data_o (ld_data)
  );

  // Bus FSM: issue on an aligned mem op, hold until ack, one DONE cycle for write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MemIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        MemIdle: begin
          if (is_mem && !mis) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {mem_mem_addr_i[RegBus-1:2], 2'b00};
            be_q    <= be;
            wdata_q <= st_data;
            state_q <= MemBusy;
          end
        end
        MemBusy: begin
          if (data_ack) begin
            rdata_q <= data_rdata;
            req_q   <= 1'b0;
            state_q <= MemDone;
          end
        end
        MemDone: state_q <= MemIdle;
        default: state_q <= MemIdle;
      endcase
    end
  end

  assign data_req   = req_q;
  assign data_we    = we_q;
  assign data_addr  = addr_q;
  assign data_be    = be_q;
  assign data_wdata = wdata_q;

  // Write-back and stall outputs; mem ops only present a result in DONE.
  always_comb begin
    wd_o     = mem_wd_i;
    wreg_o   = mem_wreg_i;
    wdata_o  = mem_wdata_i;
    stallreq = 1'b0;
    misalign = 1'b0;
    if (rst) begin
      wd_o    = '0;
      wreg_o  = WriteDisable;
      wdata_o = '0;
    end else if (is_mem) begin
      wreg_o  = WriteDisable;
      wdata_o = '0;
      if (mis) begin
        misalign = 1'b1;
      end else begin
        case (state_q)
          MemIdle, MemBusy: stallreq = 1'b1;
          MemDone: begin
            wreg_o = mem_wreg_i;
            if (!is_store) wdata_o = ld_data;
          end
          default: stallreq = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It decodes load/store aluop codes and drives a single-outstanding request/acknowledge data-SRAM bus through a small FSM. While an access is in flight it holds the pipeline via a stall request. It returns sign/zero-extended load data, or passes ALU results through, toward write-back.

## Interface
- No parameters. Widths come from `define.v`: `RegBus` = 32, `RegAddrBus` = 5, `AluOpBus` = 8.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_wd_i  in  5  destination register from EX/MEM
- mem_wreg_i  in  1  write enable from EX/MEM
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_aluop_i  in  8  operation code from EX/MEM
- mem_mem_addr_i  in  32  effective byte address
- mem_reg2_i  in  32  store source operand
- data_rdata  in  32  SRAM read data, valid with data_ack
- data_ack  in  1  SRAM completes the current request
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  write-back value to MEM/WB
- data_req  out  1  registered bus request
- data_we  out  1  registered 1 = store
- data_addr  out  32  registered word address, low 2 bits = 0
- data_be  out  4  registered byte enables, bit n = data[8n+7:8n]
- data_wdata  out  32  registered store data
- stallreq  out  1  asks the pipeline controller to hold stages 0–3
- misalign  out  1  misaligned access detected this cycle (reserved for exceptions)

## Operation
- Mem ops: LB, LBU, LH, LHU, LW, SB, SH, SW (existing `EXE_*_OP` codes). All other aluops pass through unchanged: wd/wreg/wdata = inputs, stallreq = 0, no bus activity.
- Little-endian lane selection:
  - Byte: lane = addr[1:0].
  - Half: lanes {1,0} when addr[1] = 0, {3,2} when addr[1] = 1.
  - Word: all lanes.
- Store data is replicated across lanes: SB → {4{reg2[7:0]}}, SH → {2{reg2[15:0]}}, SW → reg2. data_be is the selected lane(s).
- Loads: select the lane(s) from the captured read word. LB/LH sign-extend, LBU/LHU zero-extend.
- Misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0):
  - no bus cycle, stallreq = 0, misalign = 1;
  - wreg_o forced to WriteDisable, wdata_o = 0.
- FSM, states IDLE / BUSY / DONE:
  - IDLE: on an aligned mem op, assert stallreq combinationally, register the bus fields with data_req = 1, go to BUSY.
  - BUSY: stallreq = 1, data_req held. On data_ack: capture data_rdata, drop data_req, go to DONE.
  - DONE: stallreq = 0; a load drives the extended data, a store drives wreg_o = mem_wreg_i. Always return to IDLE on the next clock.
- Inputs stay stable from IDLE through DONE, because EX/MEM holds while stall[3] is asserted.

## Timing
- Reset (async): state = IDLE, data_req/data_we = 0, data_addr/data_be/data_wdata = 0, read-data register = 0. While rst is high: wd_o = 0, wreg_o = 0, wdata_o = 0, stallreq = 0, misalign = 0.
- Zero-wait SRAM (ack in the first BUSY cycle): 3 cycles per mem op (IDLE, BUSY, DONE). MEM/WB captures at the end of DONE. Each ack wait cycle adds one cycle.
- Non-mem ops: 0 extra cycles; outputs are combinational from the inputs.
- data_ack is ignored outside BUSY. data_req never drops before ack.
- Reset asserted during BUSY: data_req drops immediately and the request is abandoned. An ack arriving after reset release while in IDLE is ignored.
- Back-to-back mem ops: the second op starts in the IDLE cycle after DONE. There are no dead cycles beyond the FSM.

## Structure
- `define.v` gains the data-bus width and the state encoding (`MemIdle`, `MemBusy`, `MemDone`). The aluop codes are already there.
- Sub-module `mem_data_align` (combinational) computes be, replicated store data, load extension and misalign from aluop, addr[1:0], reg2 and rdata. It is shared with a future instruction-fetch bus unit.

## Test plan
- ADD result 0x0000_1234 to $5 with wreg = 1 → same cycle wd_o = 5, wdata_o = 0x0000_1234, stallreq = 0, data_req never rises.
- LB at 0x8000_0003, SRAM word 0x80FF_0102, ack in the first BUSY cycle → data_addr = 0x8000_0000, be = 0001… wait: be = 1000 (lane 3); wdata_o = 0xFFFF_FF80 in DONE; stallreq high exactly 2 cycles. LBU at the same address → 0x0000_0080.
- SH reg2 = 0x1234_ABCD at 0x8000_0002 → data_we = 1, be = 1100, data_wdata = 0xABCD_ABCD; wreg_o = 0 in DONE.
- LW at 0x8000_0010 with ack delayed 4 cycles → data_req stays high 5 cycles, stallreq high 6 cycles, wdata_o = rdata only in DONE.
- LW at 0x8000_0006 → misalign = 1, data_req = 0, wreg_o = 0, wdata_o = 0, stallreq = 0.
- rst pulse in mid-BUSY, then an ack in the following IDLE → data_req = 0 immediately, state IDLE, no write-back, late ack ignored.
